frame_renderer: RTL and testbench

FRAME_RENDERER -- requirements
Module: frame_renderer

---
 rtl/frame_renderer.sv | 194 +++++++++++++++++++
 tb/tb_frame_renderer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_renderer.sv
// -----------------------------------------------------------------------------
// frame_renderer
//
// Renders a 16x16 two-plane (red/green) game frame one row per clock.
// A frame_tick accepted while idle snapshots every game input, the next 16
// cycles fill a back buffer row by row, and one more cycle commits the back
// buffer to the visible planes, so the outputs change 17 cycles after the
// accepting edge. Ticks that arrive while a frame is in flight are dropped.
//
// Optional build macro:
//   SCORE_BAR_EN  - when defined, row 0 of the red plane shows a bar of Score
//                   lit pixels (columns 0..Score-1) in every non-IDLE state.
//                   When undefined, Score is ignored.
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset       in   synchronous, active-high
//   frame_tick  in   one-cycle frame request
//   GameState   in   [1:0]  00 IDLE, 11 GAME_OVER, 01/10 PLAY
//   BirdY       in   [3:0]  bird row
//   PipeX       in   [NUM_PIPES*4-1:0]  pipe columns, pipe i at [i*4 +: 4]
//   GapY        in   [NUM_PIPES*4-1:0]  first gap row, pipe i at [i*4 +: 4]
//   PipeValid   in   [NUM_PIPES-1:0]    per-pipe enable
//   Score       in   [3:0]  score (only with SCORE_BAR_EN)
//   RedPixels   out  [15:0][15:0]  registered red plane, [row][col]
//   GrnPixels   out  [15:0][15:0]  registered green plane, [row][col]
//   busy        out  high while a frame is rendering or committing
//   frame_done  out  one-cycle pulse in the cycle the planes update
// -----------------------------------------------------------------------------
module frame_renderer #(
    parameter int NUM_PIPES    = 2,
    parameter int GAP_SIZE     = 4,
    parameter int BIRD_X       = 12,
    parameter int BLINK_FRAMES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic [1:0]               GameState,
    input  logic [3:0]               BirdY,
    input  logic [NUM_PIPES*4-1:0]   PipeX,
    input  logic [NUM_PIPES*4-1:0]   GapY,
    input  logic [NUM_PIPES-1:0]     PipeValid,
    input  logic [3:0]               Score,
    output logic [15:0][15:0]        RedPixels,
    output logic [15:0][15:0]        GrnPixels,
    output logic                     busy,
    output logic                     frame_done
);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        RENDER = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OVER = 2'b11;

    state_t state;
    logic [3:0] row;

    // Snapshot of the game inputs taken at the accepting tick
    logic [1:0]             gstate_p0;
    logic [3:0]             birdy_p0;
    logic [NUM_PIPES*4-1:0] pipex_p0;
    logic [NUM_PIPES*4-1:0] gapy_p0;
    logic [NUM_PIPES-1:0]   pvalid_p0;
`ifdef SCORE_BAR_EN
    logic [3:0]             score_p0;
`else
    logic                   unused_score;
    assign unused_score = ^Score;
`endif

    // Game-over blink tracking, advanced once per accepted frame
    logic       blink_on;
    logic [7:0] blink_cnt;
    logic       prev_over;

    // Back buffer filled one row per RENDER cycle
    logic [15:0][15:0] red_p1;
    logic [15:0][15:0] grn_p1;

    logic [15:0] row_red;
    logic [15:0] row_grn;

    // A pipe column is solid outside its gap. The gap end is formed 5 bits
    // wide so a gap running past row 15 simply leaves the bottom rows clear.
    function automatic logic pipe_solid(input logic [3:0] r, input logic [3:0] gap);
        logic [4:0] gap_end;
        gap_end = {1'b0, gap} + 5'(GAP_SIZE);
        return (r < gap) || ({1'b0, r} >= gap_end);
    endfunction

    // ---- stage p0 -> p1: one row of pixels from the snapshot ----
    always_comb begin
        row_red = '0;
        row_grn = '0;
        if (gstate_p0 == ST_IDLE) begin
            if (row == 4'd8)
                row_red[BIRD_X] = 1'b1;
        end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (pvalid_p0[i] && pipe_solid(row, gapy_p0[i*4 +: 4]))
                    row_grn[pipex_p0[i*4 +: 4]] = 1'b1;
            end
            if ((gstate_p0 != ST_OVER || blink_on) && row == birdy_p0)
                row_red[BIRD_X] = 1'b1;
`ifdef SCORE_BAR_EN
            if (row == 4'd0) begin
                for (int c = 0; c < 16; c++) begin
                    if (5'(c) < {1'b0, score_p0})
                        row_red[c] = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT;
            row        <= 4'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            blink_on   <= 1'b1;
            blink_cnt  <= 8'd0;
            prev_over  <= 1'b0;
            red_p1     <= '0;
            grn_p1     <= '0;
            RedPixels  <= '0;
            GrnPixels  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                WAIT: begin
                    if (frame_tick) begin
                        gstate_p0 <= GameState;
                        birdy_p0  <= BirdY;
                        pipex_p0  <= PipeX;
                        gapy_p0   <= GapY;
                        pvalid_p0 <= PipeValid;
`ifdef SCORE_BAR_EN
                        score_p0  <= Score;
`endif
                        row       <= 4'd0;
                        busy      <= 1'b1;
                        state     <= RENDER;
                        // Blink restarts visible on entry to game-over and
                        // toggles every BLINK_FRAMES game-over frames after.
                        if (GameState == ST_OVER) begin
                            prev_over <= 1'b1;
                            if (!prev_over) begin
                                blink_on  <= 1'b1;
                                blink_cnt <= 8'd0;
                            end else if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
                                blink_on  <= ~blink_on;
                                blink_cnt <= 8'd0;
                            end else begin
                                blink_cnt <= blink_cnt + 8'd1;
                            end
                        end else begin
                            prev_over <= 1'b0;
                            blink_on  <= 1'b1;
                            blink_cnt <= 8'd0;
                        end
                    end
                end
                // ---- stage p1: back buffer fill ----
                RENDER: begin
                    red_p1[row] <= row_red;
                    grn_p1[row] <= row_grn;
                    row         <= row + 4'd1;
                    if (row == 4'd15)
                        state <= COMMIT;
                end
                // ---- stage p2: visible planes ----
                COMMIT: begin
                    RedPixels  <= red_p1;
                    GrnPixels  <= grn_p1;
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= WAIT;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_renderer.sv
// -----------------------------------------------------------------------------
// tb_frame_renderer
//
// Scoreboard bench for frame_renderer. Every accepted tick pushes the expected
// frame (computed pixel by pixel from the game rules) and its completion cycle
// into a queue; an independent monitor pops and compares on each frame_done.
// busy is checked against the expected frame window every cycle.
// -----------------------------------------------------------------------------
module tb_frame_renderer;

    localparam int NP  = 2;
    localparam int GAP = 4;
    localparam int BX  = 12;
    localparam int BF  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                frame_tick;
    logic [1:0]          GameState;
    logic [3:0]          BirdY;
    logic [NP*4-1:0]     PipeX;
    logic [NP*4-1:0]     GapY;
    logic [NP-1:0]       PipeValid;
    logic [3:0]          Score;
    logic [15:0][15:0]   RedPixels;
    logic [15:0][15:0]   GrnPixels;
    logic                busy;
    logic                frame_done;

    frame_renderer #(
        .NUM_PIPES(NP), .GAP_SIZE(GAP), .BIRD_X(BX), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .GameState(GameState), .BirdY(BirdY), .PipeX(PipeX), .GapY(GapY),
        .PipeValid(PipeValid), .Score(Score),
        .RedPixels(RedPixels), .GrnPixels(GrnPixels),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

`ifdef SCORE_BAR_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0][15:0] red;
        logic [15:0][15:0] grn;
        int                done_cyc;
    } exp_t;

    exp_t sbq[$];
    int last_acc   = -1000;
    int abort_edge = -1000;
    int go_run     = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected frame straight from the drawing rules
    function automatic exp_t model(input logic [1:0] st, input logic [3:0] by,
                                   input logic [NP*4-1:0] px, input logic [NP*4-1:0] gy,
                                   input logic [NP-1:0] pv, input logic [3:0] sc,
                                   input bit blink);
        exp_t e;
        int g;
        int x;
        e.red = '0;
        e.grn = '0;
        e.done_cyc = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                if (st == 2'b00) begin
                    e.red[r][c] = (r == 8 && c == BX);
                end else begin
                    e.red[r][c] = (r == int'(by) && c == BX && (st != 2'b11 || blink))
                                  || (SCORE_EN && r == 0 && c < int'(sc));
                    for (int i = 0; i < NP; i++) begin
                        g = int'(gy[i*4 +: 4]);
                        x = int'(px[i*4 +: 4]);
                        if (pv[i] && c == x && (r < g || r >= g + GAP))
                            e.grn[r][c] = 1'b1;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic do_tick();
        int e;
        bit blink;
        exp_t x;
        @(negedge clk);
        frame_tick = 1'b1;
        e = cyc + 1;
        if (!reset && ((e >= last_acc + 18) || (abort_edge > last_acc && e > abort_edge))) begin
            if (GameState == 2'b11) begin
                go_run++;
                blink = (((go_run - 1) / BF) % 2) == 0;
            end else begin
                go_run = 0;
                blink  = 1'b1;
            end
            x = model(GameState, BirdY, PipeX, GapY, PipeValid, Score, blink);
            x.done_cyc = e + 17;
            sbq.push_back(x);
            last_acc = e;
        end
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        abort_edge = cyc + 1;
        while (sbq.size() > 0 && sbq[$].done_cyc >= abort_edge)
            void'(sbq.pop_back());
        go_run = 0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic rand_inputs();
        GameState = ($urandom % 2 == 1) ? 2'b11 : 2'($urandom_range(0, 3));
        BirdY     = 4'($urandom);
        PipeX     = NP*4'($urandom);
        GapY      = NP*4'($urandom);
        PipeValid = NP'($urandom);
        Score     = 4'($urandom);
    endtask

    // Scoreboard monitor and per-cycle busy check
    always @(negedge clk) begin
        exp_t x;
        bit exp_busy;
        if (frame_done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_frame_done", 256'(cyc), 256'(0));
            end else begin
                x = sbq.pop_front();
                chk("done_cycle", 256'(cyc), 256'(x.done_cyc));
                chk("red_plane", RedPixels, x.red);
                chk("grn_plane", GrnPixels, x.grn);
            end
        end
        if (sbq.size() > 0 && sbq[0].done_cyc < cyc) begin
            chk("missed_frame_done", 256'(0), 256'(sbq[0].done_cyc));
            void'(sbq.pop_front());
        end
        exp_busy = (cyc >= last_acc && cyc <= last_acc + 16)
                   && !(abort_edge > last_acc && cyc >= abort_edge);
        chk("busy", 256'(busy), 256'(exp_busy));
    end

    initial begin
        bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int w;
        reset = 1'b1; frame_tick = 1'b0; GameState = 2'b00; BirdY = 4'd0;
        PipeX = '0; GapY = '0; PipeValid = '0; Score = 4'd0;
        do_reset(3);
        chk("reset_red", RedPixels, 256'(0));
        chk("reset_grn", GrnPixels, 256'(0));
        chk("reset_done", 256'(frame_done), 256'(0));

        // IDLE frame: single red pixel at [8][BIRD_X]
        do_tick();
        repeat (18) @(negedge clk);
        chk("idle_red_8_12", 256'(RedPixels[8][12]), 256'(1));

        // PLAY with two pipes
        GameState = 2'b01; BirdY = 4'd4;
        PipeX = {4'd10, 4'd5}; GapY = {4'd2, 4'd6}; PipeValid = 2'b11; Score = 4'd3;
        do_tick();
        repeat (18) @(negedge clk);
        chk("play_grn_0_5",  256'(GrnPixels[0][5]),  256'(1));
        chk("play_grn_6_5",  256'(GrnPixels[6][5]),  256'(0));
        chk("play_grn_10_5", 256'(GrnPixels[10][5]), 256'(1));
        chk("play_grn_1_10", 256'(GrnPixels[1][10]), 256'(1));
        chk("play_grn_2_10", 256'(GrnPixels[2][10]), 256'(0));
        chk("play_grn_6_10", 256'(GrnPixels[6][10]), 256'(1));
        chk("play_red_4_12", 256'(RedPixels[4][12]), 256'(1));
`ifdef SCORE_BAR_EN
        chk("score_bar_row0", 256'(RedPixels[0]), 256'(16'h0007));
`else
        chk("no_score_bar_row0", 256'(RedPixels[0]), 256'(0));
`endif

        // Gap running off the bottom
        PipeX = {4'd0, 4'd3}; GapY = {4'd0, 4'd14}; PipeValid = 2'b01;
        do_tick();
        repeat (18) @(negedge clk);
        chk("gap_grn_13_3", 256'(GrnPixels[13][3]), 256'(1));
        chk("gap_grn_14_3", 256'(GrnPixels[14][3]), 256'(0));
        chk("gap_grn_15_3", 256'(GrnPixels[15][3]), 256'(0));

        // Snapshot isolation and ignored tick while busy
        BirdY = 4'd4;
        do_tick();
        @(negedge clk);
        BirdY = 4'd9;
        repeat (2) @(negedge clk);
        do_tick();
        repeat (18) @(negedge clk);
        chk("snap_red_4_12", 256'(RedPixels[4][12]), 256'(1));
        chk("snap_red_9_12", 256'(RedPixels[9][12]), 256'(0));

        // Game-over blink sequence, entered from PLAY
        GameState = 2'b11; BirdY = 4'd7;
        for (int k = 0; k < 6; k++) begin
            do_tick();
            repeat (18) @(negedge clk);
            chk($sformatf("blink_frame%0d", k), 256'(RedPixels[7][12]), 256'(pat[k]));
        end

        // Reset while rendering row 7 aborts the frame
        GameState = 2'b01; BirdY = 4'd2; PipeValid = 2'b11;
        do_tick();
        repeat (6) @(negedge clk);
        do_reset(1);
        chk("abort_red_zero", RedPixels, 256'(0));
        chk("abort_grn_zero", GrnPixels, 256'(0));
        repeat (22) @(negedge clk);

        // Reset coincident with a tick wins
        @(negedge clk);
        reset = 1'b1; frame_tick = 1'b1;
        abort_edge = cyc + 1; go_run = 0;
        @(negedge clk);
        reset = 1'b0; frame_tick = 1'b0;
        repeat (3) @(negedge clk);

        // Randomized traffic with mid-frame input changes and stray ticks
        for (int n = 0; n < 40; n++) begin
            rand_inputs();
            do_tick();
            repeat ($urandom_range(1, 10)) @(negedge clk);
            rand_inputs();
            if ($urandom % 2 == 1) do_tick();
            repeat ($urandom_range(4, 20)) @(negedge clk);
        end

        w = 0;
        while (sbq.size() > 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drained", 256'(sbq.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
